// File: rtl/w0rm_store_pkg.sv
// Shared encodings for the store-narrow path: access sizes, flag bit
// positions, FSM states and a beat-count helper.
package w0rm_store_pkg;

    localparam int unsigned NUM_FLAGS  = 4;
    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_NEG   = 1;
    localparam int unsigned FLAG_OVER  = 2;
    localparam int unsigned FLAG_CARRY = 3;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Index of the final beat for a given access size
    function automatic logic [1:0] last_beat(input size_e size);
        case (size)
            SIZE_HALF: last_beat = 2'd1;
            SIZE_WORD: last_beat = 2'd3;
            default:   last_beat = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/w0rm_store_narrow_flags.sv
// Combinational narrowing of a register value to byte/half/word and the
// resulting zero/neg/over/carry flags. Reserved size yields all-zero flags.
import w0rm_store_pkg::*;

module w0rm_store_narrow_flags #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_size,
    output logic [NUM_FLAGS-1:0]  o_flags_c
);

    logic [DATA_WIDTH-1:0] w_sext;
    logic [DATA_WIDTH-1:0] w_zext;
    logic                  w_neg;
    logic                  w_valid;

    // Sign- and zero-extended views of the narrowed value
    always_comb begin
        w_sext  = '0;
        w_zext  = '0;
        w_neg   = 1'b0;
        w_valid = 1'b1;
        case (size_e'(i_size))
            SIZE_BYTE: begin
                w_zext = DATA_WIDTH'(i_data[7:0]);
                w_sext = {{(DATA_WIDTH-8){i_data[7]}}, i_data[7:0]};
                w_neg  = i_data[7];
            end
            SIZE_HALF: begin
                w_zext = DATA_WIDTH'(i_data[15:0]);
                w_sext = {{(DATA_WIDTH-16){i_data[15]}}, i_data[15:0]};
                w_neg  = i_data[15];
            end
            SIZE_WORD: begin
                w_zext = i_data;
                w_sext = i_data;
                w_neg  = i_data[DATA_WIDTH-1];
            end
            default: w_valid = 1'b0;
        endcase
    end

    // Flag vector; zero test on the zero-extended value equals n==0
    always_comb begin
        o_flags_c = '0;
        if (w_valid) begin
            o_flags_c[FLAG_ZERO]  = (w_zext == '0);
            o_flags_c[FLAG_NEG]   = w_neg;
            o_flags_c[FLAG_OVER]  = (i_data != w_sext);
            o_flags_c[FLAG_CARRY] = (i_data != w_zext);
        end
    end

endmodule

// File: rtl/w0rm_store_narrow.sv
// Store-side narrowing and byte-serial write port. Latches a store request,
// emits 1/2/4 little-endian byte beats with valid/ready, then pulses done
// with the truncation flags.
// Optional alignment rejection: define W0RM_STORE_NARROW_ALIGN_CHECK_EN.
import w0rm_store_pkg::*;

module w0rm_store_narrow #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_data_valid,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_mem_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [BUS_WIDTH-1:0]  o_mem_data,
    input  logic                  i_mem_ready,
    output logic                  o_done,
    output logic [NUM_FLAGS-1:0]  o_result_flags,
    output logic                  o_misaligned
);

    state_e                r_state,     w_state_nxt;
    logic                  r_ready,     w_ready_nxt;
    logic                  r_mem_valid, w_mem_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [BUS_WIDTH-1:0]  r_mem_data,  w_mem_data_nxt;
    logic [DATA_WIDTH-1:0] r_shift,     w_shift_nxt;
    logic [1:0]            r_count,     w_count_nxt;
    logic [1:0]            r_last,      w_last_nxt;
    logic [NUM_FLAGS-1:0]  r_pend,      w_pend_nxt;
    logic [NUM_FLAGS-1:0]  r_flags,     w_flags_nxt;
    logic                  r_done,      w_done_nxt;
    logic                  r_mis,       w_mis_nxt;

    logic                  w_accept;
    logic                  w_misaligned;
    logic [NUM_FLAGS-1:0]  w_flags_c;

    assign w_accept = i_data_valid & r_ready;

`ifdef W0RM_STORE_NARROW_ALIGN_CHECK_EN
    // Half needs even address, word needs 4-byte alignment
    assign w_misaligned = w_accept &
        (((size_e'(i_size) == SIZE_HALF) & i_addr[0]) |
         ((size_e'(i_size) == SIZE_WORD) & (i_addr[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    w0rm_store_narrow_flags #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_flags (
        .i_data    (i_data),
        .i_size    (i_size),
        .o_flags_c (w_flags_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_shift     <= '0;
            r_count     <= '0;
            r_last      <= '0;
            r_pend      <= '0;
            r_flags     <= '0;
            r_done      <= 1'b0;
            r_mis       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= w_ready_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_shift     <= w_shift_nxt;
            r_count     <= w_count_nxt;
            r_last      <= w_last_nxt;
            r_pend      <= w_pend_nxt;
            r_flags     <= w_flags_nxt;
            r_done      <= w_done_nxt;
            r_mis       <= w_mis_nxt;
        end
    end

    // Next-state: accept in IDLE, advance beats in SEND on each handshake
    always_comb begin
        w_state_nxt     = r_state;
        w_ready_nxt     = r_ready;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        w_shift_nxt     = r_shift;
        w_count_nxt     = r_count;
        w_last_nxt      = r_last;
        w_pend_nxt      = r_pend;
        w_flags_nxt     = r_flags;
        w_done_nxt      = 1'b0;
        w_mis_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_mis_nxt   = 1'b1;
                        w_flags_nxt = '0;
                    end else if (size_e'(i_size) == SIZE_RSVD) begin
                        w_done_nxt  = 1'b1;
                        w_flags_nxt = '0;
                    end else begin
                        w_state_nxt     = ST_SEND;
                        w_ready_nxt     = 1'b0;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addr_nxt  = i_addr;
                        w_mem_data_nxt  = i_data[BUS_WIDTH-1:0];
                        w_shift_nxt     = i_data >> BUS_WIDTH;
                        w_count_nxt     = 2'd0;
                        w_last_nxt      = last_beat(size_e'(i_size));
                        w_pend_nxt      = w_flags_c;
                    end
                end
            end
            ST_SEND: begin
                if (i_mem_ready) begin
                    if (r_count == r_last) begin
                        w_state_nxt     = ST_IDLE;
                        w_ready_nxt     = 1'b1;
                        w_mem_valid_nxt = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_flags_nxt     = r_pend;
                    end else begin
                        w_count_nxt    = r_count + 2'd1;
                        w_mem_addr_nxt = r_mem_addr + ADDR_WIDTH'(1);
                        w_mem_data_nxt = r_shift[BUS_WIDTH-1:0];
                        w_shift_nxt    = r_shift >> BUS_WIDTH;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_ready        = r_ready;
    assign o_mem_valid    = r_mem_valid;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_data     = r_mem_data;
    assign o_done         = r_done;
    assign o_result_flags = r_flags;
    assign o_misaligned   = r_mis;

endmodule

// File: tb/tb_w0rm_store_narrow.sv
// Scoreboard bench for w0rm_store_narrow: requests push expected beats and
// done/misaligned events; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_w0rm_store_narrow;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        i_data_valid;
    logic [1:0]  i_size;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_mem_valid;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_data;
    logic        i_mem_ready;
    logic        o_done;
    logic [3:0]  o_result_flags;
    logic        o_misaligned;

    int n_checks = 0;
    int n_pass   = 0;
    int n_beats  = 0;
    int n_dones  = 0;

    beat_t      beat_q[$];
    logic [3:0] done_q[$];
    int         mis_q[$];

    w0rm_store_narrow dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_data_valid   (i_data_valid),
        .i_size         (i_size),
        .i_addr         (i_addr),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .o_mem_valid    (o_mem_valid),
        .o_mem_addr     (o_mem_addr),
        .o_mem_data     (o_mem_data),
        .i_mem_ready    (i_mem_ready),
        .o_done         (o_done),
        .o_result_flags (o_result_flags),
        .o_misaligned   (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Monitor: compare every handshake, done and misaligned event
    logic        stalled = 1'b0;
    logic [31:0] prev_addr;
    logic [7:0]  prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", {o_mem_valid, o_mem_addr, o_mem_data},
                      {1'b1, prev_addr, prev_data});
            if (o_mem_valid && i_mem_ready) begin
                n_beats++;
                if (beat_q.size() == 0) unexpected("beat");
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_addr", o_mem_addr, b.addr);
                    check("beat_data", o_mem_data, b.data);
                end
            end
            stalled   = o_mem_valid && !i_mem_ready;
            prev_addr = o_mem_addr;
            prev_data = o_mem_data;
            if (o_done) begin
                n_dones++;
                if (done_q.size() == 0) unexpected("done");
                else check("done_flags", o_result_flags, done_q.pop_front());
            end
            if (o_misaligned) begin
                if (mis_q.size() == 0) unexpected("misaligned");
                else begin
                    void'(mis_q.pop_front());
                    check("mis_flags", {o_mem_valid, o_done, o_result_flags}, 6'b0);
                end
            end
        end
    end

    // Issue one request, queue its expectations, return just after acceptance
    task automatic send_req(input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] fl,
                            input bit abandon);
        int  nb;
        bit  mis;
        bit  accepted;
        mis = 1'b0;
`ifdef W0RM_STORE_NARROW_ALIGN_CHECK_EN
        mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        if (abandon) nb = 2;
        if (mis) mis_q.push_back(1);
        else begin
            for (int k = 0; k < nb; k++) begin
                beat_t b;
                b.addr = a + 32'(k);
                b.data = d[8*k +: 8];
                beat_q.push_back(b);
            end
            if (!abandon) done_q.push_back(fl);
        end
        i_size       = sz;
        i_addr       = a;
        i_data       = d;
        i_data_valid = 1'b1;
        accepted     = 1'b0;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clk);
            if (o_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        i_data_valid = 1'b0;
        if (!accepted) unexpected("accept_timeout");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    logic [6:0] pat;
    int         beats0;
    int         dones0;

    initial begin
        rst_n        = 1'b0;
        i_data_valid = 1'b0;
        i_size       = 2'b00;
        i_addr       = '0;
        i_data       = '0;
        i_mem_ready  = 1'b1;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", o_ready, 1);
        check("rst_mem_valid", o_mem_valid, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_data", o_mem_data, 0);
        check("rst_done", o_done, 0);
        check("rst_misaligned", o_misaligned, 0);
        check("rst_flags", o_result_flags, 0);
        @(posedge clk); #1;

        // Byte 0x80: Z0 N1 V1 C0, beat at N+1, done at N+2
        send_req(2'b00, 32'h100, 32'h0000_0080, 4'b0110, 1'b0);
        @(negedge clk);
        check("t1_beat_latency", {o_mem_valid, o_ready}, 2'b10);
        @(negedge clk);
        check("t1_done_latency", {o_done, o_ready, o_mem_valid}, 3'b110);
        idle(2);

        // Word with stalls; a data_valid pulse mid-transfer must be ignored
        beats0 = n_beats;
        dones0 = n_dones;
        send_req(2'b10, 32'h200, 32'h1234_5678, 4'b0000, 1'b0);
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            i_mem_ready  = pat[i];
            i_data_valid = (i == 2);
            i_size       = 2'b00;
            i_addr       = 32'h300;
            i_data       = 32'h0000_00AA;
            @(posedge clk); #1;
        end
        i_data_valid = 1'b0;
        i_mem_ready  = 1'b1;
        idle(4);
        check("t4_beat_count", n_beats - beats0, 4);
        check("t4_done_count", n_dones - dones0, 1);

        // Half 0xFFFF8000: N1 C1
        send_req(2'b01, 32'h10, 32'hFFFF_8000, 4'b1010, 1'b0);
        // Back-to-back: second request accepted in the done cycle
        send_req(2'b00, 32'h20, 32'h0000_0000, 4'b0001, 1'b0);
        send_req(2'b00, 32'h30, 32'h0000_017F, 4'b1100, 1'b0);
        // Reserved size: no beats, done with zero flags
        send_req(2'b11, 32'h40, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        idle(4);

        // Reset while beat 2 of a word is presented
        i_mem_ready = 1'b1;
        send_req(2'b10, 32'h500, 32'hCAFE_F00D, 4'b0000, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_mem_ready = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        i_mem_ready = 1'b1;
        @(negedge clk);
        check("t5_after_reset", {o_mem_valid, o_ready, o_done}, 3'b010);
        idle(6);

        // Misaligned half (0xABCD: N1 V1) and a wrapping half
        send_req(2'b01, 32'h101, 32'h0000_ABCD, 4'b0110, 1'b0);
        idle(4);
        send_req(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 1'b0);

        for (int t = 0; t < 50 && (beat_q.size() + done_q.size() + mis_q.size()) != 0; t++)
            idle(1);
        idle(3);
        check("beat_q_empty", beat_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("mis_q_empty", mis_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
